alarm_clock: RTL and testbench
==============================

# alarm_clock

Digital 24-hour alarm clock block. It keeps current time as BCD hours and minutes, advanced from the system clock by an internal prescaler and seconds counter. It holds one programmable alarm time and raises a latched alarm output when the time matches and the alarm is armed. The time digits feed the display driver directly.

## Interface
Parameters:
- CLKS_PER_SEC, default 10: clock cycles per second; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- hourIn1  in  2  hour tens digit to load (0–2).
- hourIn0  in  4  hour units digit to load (BCD).
- minIn1  in  4  minute tens digit to load (0–5).
- minIn0  in  4  minute units digit to load (BCD).
- ldTime  in  1  load the In digits into current time.
- ldAlarm  in  1  load the In digits into the alarm register.
- alarmOn  in  1  arm the alarm; 0 disarms it and clears the alarm output.
- alarm  out  1  alarm ringing, registered.
- hourOut1  out  2  current hour tens digit, registered.
- hourOut0  out  4  current hour units digit, registered.
- minOut1  out  4  current minute tens digit, registered.
- minOut0  out  4  current minute units digit, registered.

## Operation
- State:
  - Prescaler: 0..CLKS_PER_SEC-1.
  - Seconds: 0..59, binary, internal only.
  - Current time: 4 BCD digits.
  - Alarm time: 4 BCD digits.
  - Alarm flag.
- Reset (reset=0):
  - Current time and alarm time are 00:00.
  - Seconds = 0, prescaler = 0.
  - alarm = 0.
  - All outputs take these values immediately, without waiting for a clock edge.
- ldTime=1 at an edge:
  - Current time takes the input digits.
  - Seconds and prescaler clear to 0.
  - Normal counting is suppressed that cycle.
- ldAlarm=1 at an edge: alarm time takes the input digits.
- ldTime and ldAlarm both high: both registers load the same digits.
- Counting, when ldTime=0:
  - The prescaler increments every cycle.
  - When the prescaler reaches CLKS_PER_SEC-1 it wraps to 0 and seconds increment.
  - When seconds go from 59 to 0, minutes increment.
- Minute increment is BCD:
  - minOut0 goes 9→0 with a carry into minOut1.
  - minOut1 goes 5→0 with a carry into the hour.
- Hour increment is BCD:
  - hourOut0 goes 9→0 with a carry into hourOut1.
  - 23 wraps to 00.
  - 23:59:59 rolls over to 00:00:00.
- Alarm:
  - Match means current HH:MM equals alarm HH:MM. The seconds value does not take part in the match.
  - At each edge, if alarmOn=1 and match, the flag sets.
  - Once set, the flag stays set while alarmOn=1, even after the minute passes.
  - alarmOn=0 clears the flag at the next edge and blocks setting.
  - Arming during a matching minute sets alarm at the next edge.
  - Reloading time or alarm does not clear the flag.
- Loads are not range-checked unless ALARM_VALIDATE_EN is defined. Out-of-range values then count along the BCD wrap rules (a digit above 9 increments to the next value until its wrap compare matches). This behaviour is unspecified and not tested.

## Timing
- Load latency: outputs show loaded digits 1 cycle after the ldTime edge.
- After a time load, the first minute increment occurs 60×CLKS_PER_SEC edges later.
- Alarm latency: alarm rises at the edge after the cycle in which the outputs match. This is 1 cycle after the minute digit update.
- Alarm disarm latency: alarm falls 1 edge after alarmOn samples 0.
- Asynchronous reset may be asserted mid-count. All state returns to reset values, and counting resumes from 00:00:00 on the first edge after release.

## Configuration
- ALARM_VALIDATE_EN defined:
  - A load whose digits are invalid is ignored entirely; the target register is unchanged.
  - Invalid means hour > 23, minIn1 > 5, or any unit digit > 9.
  - For ldTime, an ignored load also leaves seconds and the prescaler counting.
- ALARM_VALIDATE_EN undefined: loads are unchecked, as above.

## Test plan
Use CLKS_PER_SEC=2 for all scenarios.
- Reset low for 3 cycles, then release → all time outputs 0, alarm=0. Time reads 00:01 after 120 edges.
- Load 12:12 with one ldTime cycle → outputs 12:12 on the next edge. 12:13 appears exactly 120 edges later.
- Load 23:59 → after 120 edges, outputs 00:00. Load 09:59 → after 120 edges, 10:00.
- Load time 12:18, alarm 12:19, alarmOn=1 → alarm rises 1 cycle after minOut0 becomes 9. It stays 1 at 12:20. Set alarmOn=0 → alarm 0 on the next edge.
- Same as the previous scenario with alarmOn held 0 → alarm stays 0 through 12:19. Raise alarmOn while the time is 12:19 → alarm=1 on the next edge.
- With ALARM_VALIDATE_EN defined: ldTime with 25:70 → time unchanged. ldAlarm with 12:0A → alarm register unchanged, verified by no alarm at 12:00.

Source files
------------

// File: rtl/alarm_clock.sv
// 24-hour BCD alarm clock: prescaler, seconds counter, HH:MM time, one alarm register and a latched alarm flag.
// Optional build macro ALARM_VALIDATE_EN: loads with out-of-range digits are ignored.
module alarm_clock #(
    parameter int CLKS_PER_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] hourIn1,
    input  logic [3:0] hourIn0,
    input  logic [3:0] minIn1,
    input  logic [3:0] minIn0,
    input  logic       ldTime,
    input  logic       ldAlarm,
    input  logic       alarmOn,
    output logic       alarm,
    output logic [1:0] hourOut1,
    output logic [3:0] hourOut0,
    output logic [3:0] minOut1,
    output logic [3:0] minOut0
);

    localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    logic [PW-1:0] r_presc;
    logic [5:0]    r_sec;
    logic [1:0]    r_h1;
    logic [3:0]    r_h0;
    logic [3:0]    r_m1;
    logic [3:0]    r_m0;
    logic [1:0]    r_ah1;
    logic [3:0]    r_ah0;
    logic [3:0]    r_am1;
    logic [3:0]    r_am0;
    logic          r_alarm;

    logic [PW-1:0] w_presc_n;
    logic [5:0]    w_sec_n;
    logic [1:0]    w_h1_n;
    logic [3:0]    w_h0_n;
    logic [3:0]    w_m1_n;
    logic [3:0]    w_m0_n;
    logic [1:0]    w_ah1_n;
    logic [3:0]    w_ah0_n;
    logic [3:0]    w_am1_n;
    logic [3:0]    w_am0_n;
    logic          w_alarm_n;
    logic          w_ld_ok;
    logic          w_ld_time;
    logic          w_ld_alarm;
    logic          w_sec_tick;
    logic          w_min_tick;
    logic          w_match;

`ifdef ALARM_VALIDATE_EN
    function automatic logic digits_valid(input logic [1:0] h1, input logic [3:0] h0,
                                          input logic [3:0] m1, input logic [3:0] m0);
        logic hour_ok;
        hour_ok = ((h1 < 2'd2) && (h0 <= 4'd9)) || ((h1 == 2'd2) && (h0 <= 4'd3));
        return hour_ok && (m1 <= 4'd5) && (m0 <= 4'd9);
    endfunction

    assign w_ld_ok = digits_valid(hourIn1, hourIn0, minIn1, minIn0);
`else
    assign w_ld_ok = 1'b1;
`endif

    assign w_ld_time  = ldTime & w_ld_ok;
    assign w_ld_alarm = ldAlarm & w_ld_ok;
    assign w_sec_tick = (r_presc == PRESC_MAX);
    assign w_min_tick = w_sec_tick && (r_sec == 6'd59);
    assign w_match    = (r_h1 == r_ah1) && (r_h0 == r_ah0) && (r_m1 == r_am1) && (r_m0 == r_am0);

    // Next-state for the time base, BCD time digits, alarm register and alarm flag.
    always_comb begin
        w_presc_n = r_presc;
        w_sec_n   = r_sec;
        w_h1_n    = r_h1;
        w_h0_n    = r_h0;
        w_m1_n    = r_m1;
        w_m0_n    = r_m0;
        w_ah1_n   = r_ah1;
        w_ah0_n   = r_ah0;
        w_am1_n   = r_am1;
        w_am0_n   = r_am0;

        if (w_ld_time) begin
            w_presc_n = '0;
            w_sec_n   = 6'd0;
            w_h1_n    = hourIn1;
            w_h0_n    = hourIn0;
            w_m1_n    = minIn1;
            w_m0_n    = minIn0;
        end else begin
            if (w_sec_tick) begin
                w_presc_n = '0;
                if (r_sec == 6'd59) begin
                    w_sec_n = 6'd0;
                end else begin
                    w_sec_n = r_sec + 6'd1;
                end
            end else begin
                w_presc_n = r_presc + PRESC_ONE;
                w_sec_n   = r_sec;
            end

            if (w_min_tick) begin
                if (r_m0 == 4'd9) begin
                    w_m0_n = 4'd0;
                    if (r_m1 == 4'd5) begin
                        w_m1_n = 4'd0;
                        // Hour carry: 23 wraps to 00 before the units-digit rule applies.
                        if ((r_h1 == 2'd2) && (r_h0 == 4'd3)) begin
                            w_h1_n = 2'd0;
                            w_h0_n = 4'd0;
                        end else if (r_h0 == 4'd9) begin
                            w_h1_n = r_h1 + 2'd1;
                            w_h0_n = 4'd0;
                        end else begin
                            w_h1_n = r_h1;
                            w_h0_n = r_h0 + 4'd1;
                        end
                    end else begin
                        w_m1_n = r_m1 + 4'd1;
                    end
                end else begin
                    w_m0_n = r_m0 + 4'd1;
                end
            end else begin
                w_m0_n = r_m0;
            end
        end

        if (w_ld_alarm) begin
            w_ah1_n = hourIn1;
            w_ah0_n = hourIn0;
            w_am1_n = minIn1;
            w_am0_n = minIn0;
        end else begin
            w_ah1_n = r_ah1;
        end

        // Flag latches while armed; match uses the currently displayed time.
        w_alarm_n = alarmOn & (r_alarm | w_match);
    end

    // State registers with asynchronous active-low reset to 00:00:00.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
            r_sec   <= 6'd0;
            r_h1    <= 2'd0;
            r_h0    <= 4'd0;
            r_m1    <= 4'd0;
            r_m0    <= 4'd0;
            r_ah1   <= 2'd0;
            r_ah0   <= 4'd0;
            r_am1   <= 4'd0;
            r_am0   <= 4'd0;
            r_alarm <= 1'b0;
        end else begin
            r_presc <= w_presc_n;
            r_sec   <= w_sec_n;
            r_h1    <= w_h1_n;
            r_h0    <= w_h0_n;
            r_m1    <= w_m1_n;
            r_m0    <= w_m0_n;
            r_ah1   <= w_ah1_n;
            r_ah0   <= w_ah0_n;
            r_am1   <= w_am1_n;
            r_am0   <= w_am0_n;
            r_alarm <= w_alarm_n;
        end
    end

    assign alarm    = r_alarm;
    assign hourOut1 = r_h1;
    assign hourOut0 = r_h0;
    assign minOut1  = r_m1;
    assign minOut0  = r_m0;

endmodule

// File: tb/tb_alarm_clock.sv
// Directed bench for alarm_clock with CLKS_PER_SEC=2; expected {alarm,HH,MM} values go through a scoreboard queue.
module tb_alarm_clock;

    localparam int CPS = 2;
    localparam int MIN_EDGES = 60 * CPS;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] hourIn1;
    logic [3:0] hourIn0;
    logic [3:0] minIn1;
    logic [3:0] minIn0;
    logic       ldTime;
    logic       ldAlarm;
    logic       alarmOn;
    logic       alarm;
    logic [1:0] hourOut1;
    logic [3:0] hourOut0;
    logic [3:0] minOut1;
    logic [3:0] minOut0;

    typedef struct {
        string       tag;
        logic [14:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    alarm_clock #(.CLKS_PER_SEC(CPS)) dut (
        .clk      (clk),
        .reset    (reset),
        .hourIn1  (hourIn1),
        .hourIn0  (hourIn0),
        .minIn1   (minIn1),
        .minIn0   (minIn0),
        .ldTime   (ldTime),
        .ldAlarm  (ldAlarm),
        .alarmOn  (alarmOn),
        .alarm    (alarm),
        .hourOut1 (hourOut1),
        .hourOut0 (hourOut0),
        .minOut1  (minOut1),
        .minOut0  (minOut0)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Expected value built from decimal hours/minutes, split into BCD digits here.
    task automatic push_exp(input string tag, input logic a, input int hh, input int mm);
        exp_t e;
        e.tag = tag;
        e.val = {a, 2'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [14:0] obs;
        obs = {alarm, hourOut1, hourOut0, minOut1, minOut0};
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %h required <queued value>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input int h1, input int h0, input int m1, input int m0);
        hourIn1 = 2'(h1);
        hourIn0 = 4'(h0);
        minIn1  = 4'(m1);
        minIn0  = 4'(m0);
    endtask

    task automatic load_time(input int h1, input int h0, input int m1, input int m0);
        set_digits(h1, h0, m1, m0);
        ldTime = 1'b1;
        step(1);
        ldTime = 1'b0;
    endtask

    task automatic load_alarm(input int h1, input int h0, input int m1, input int m0);
        set_digits(h1, h0, m1, m0);
        ldAlarm = 1'b1;
        step(1);
        ldAlarm = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        ldTime  = 1'b0;
        ldAlarm = 1'b0;
        alarmOn = 1'b0;
        set_digits(0, 0, 0, 0);

        // Reset: outputs clear without a clock edge, then count from 00:00:00.
        #1;
        push_exp("reset_async", 1'b0, 0, 0);
        check_out();
        push_exp("reset_held", 1'b0, 0, 0);
        step(3);
        check_out();
        reset = 1'b1;
        push_exp("post_reset_119", 1'b0, 0, 0);
        step(MIN_EDGES - 1);
        check_out();
        push_exp("post_reset_120", 1'b0, 0, 1);
        step(1);
        check_out();

        // Time load and the first minute increment 120 edges later.
        push_exp("load_1212", 1'b0, 12, 12);
        load_time(1, 2, 1, 2);
        check_out();
        push_exp("1212_edge119", 1'b0, 12, 12);
        step(MIN_EDGES - 1);
        check_out();
        push_exp("1213_edge120", 1'b0, 12, 13);
        step(1);
        check_out();

        // Day and hour-tens rollovers.
        push_exp("load_2359", 1'b0, 23, 59);
        load_time(2, 3, 5, 9);
        check_out();
        push_exp("wrap_0000", 1'b0, 0, 0);
        step(MIN_EDGES);
        check_out();
        push_exp("load_0959", 1'b0, 9, 59);
        load_time(0, 9, 5, 9);
        check_out();
        push_exp("carry_1000", 1'b0, 10, 0);
        step(MIN_EDGES);
        check_out();

        // Armed alarm: rises one edge after the match minute appears and latches.
        push_exp("ld_alarm_keeps_time", 1'b0, 10, 0);
        load_alarm(1, 2, 1, 9);
        check_out();
        alarmOn = 1'b1;
        push_exp("load_1218_armed", 1'b0, 12, 18);
        load_time(1, 2, 1, 8);
        check_out();
        push_exp("armed_1218", 1'b0, 12, 18);
        step(MIN_EDGES - 1);
        check_out();
        push_exp("armed_1219_same_edge", 1'b0, 12, 19);
        step(1);
        check_out();
        push_exp("armed_rise", 1'b1, 12, 19);
        step(1);
        check_out();
        push_exp("armed_latched_1220", 1'b1, 12, 20);
        step(MIN_EDGES - 1);
        check_out();
        alarmOn = 1'b0;
        push_exp("disarm_clears", 1'b0, 12, 20);
        step(1);
        check_out();

        // Disarmed through the match, then armed during the matching minute.
        push_exp("load_1218_disarmed", 1'b0, 12, 18);
        load_time(1, 2, 1, 8);
        check_out();
        push_exp("disarmed_1219", 1'b0, 12, 19);
        step(MIN_EDGES);
        check_out();
        push_exp("disarmed_hold", 1'b0, 12, 19);
        step(5);
        check_out();
        alarmOn = 1'b1;
        push_exp("arm_in_match", 1'b1, 12, 19);
        step(1);
        check_out();
        push_exp("reload_keeps_flag", 1'b1, 5, 0);
        load_time(0, 5, 0, 0);
        check_out();
        alarmOn = 1'b0;
        push_exp("disarm_after_reload", 1'b0, 5, 0);
        step(1);
        check_out();

        // Asynchronous reset mid-count.
        push_exp("midcount_reset_async", 1'b0, 0, 0);
        step(37);
        reset = 1'b0;
        #1;
        check_out();
        step(2);
        reset = 1'b1;
        push_exp("midcount_reset_119", 1'b0, 0, 0);
        step(MIN_EDGES - 1);
        check_out();
        push_exp("midcount_reset_120", 1'b0, 0, 1);
        step(1);
        check_out();

`ifdef ALARM_VALIDATE_EN
        // Invalid loads are ignored; the seconds count keeps running.
        push_exp("v_ld_alarm_1201", 1'b0, 0, 1);
        load_alarm(1, 2, 0, 1);
        check_out();
        push_exp("v_load_1159", 1'b0, 11, 59);
        load_time(1, 1, 5, 9);
        check_out();
        step(10);
        push_exp("v_bad_time_ignored", 1'b0, 11, 59);
        load_time(2, 5, 7, 0);
        check_out();
        push_exp("v_bad_alarm_load", 1'b0, 11, 59);
        load_alarm(1, 2, 0, 10);
        check_out();
        alarmOn = 1'b1;
        push_exp("v_count_continued", 1'b0, 12, 0);
        step(MIN_EDGES - 12);
        check_out();
        push_exp("v_no_alarm_1200", 1'b0, 12, 0);
        step(1);
        check_out();
        push_exp("v_1201_edge", 1'b0, 12, 1);
        step(MIN_EDGES - 1);
        check_out();
        push_exp("v_alarm_reg_kept", 1'b1, 12, 1);
        step(1);
        check_out();
        alarmOn = 1'b0;
`endif

        if (sb.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb_leftover: observed %0d entries required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
